trackball_counter: RTL and testbench
====================================

Name: trackball_counter

Overview:
- Downstream consumer of the trackball emulator's quadrature-style outputs: h_clk/h_dir and v_clk/v_dir.
- Converts each toggling clock/direction pair into a 4-bit wrapping position counter plus a direction bit, in the format the CPU reads on its input ports.
- Presents CPU-facing registers that freeze while a read strobe is held, giving tear-free reads while counting continues underneath.

Parameters:
- AXIS_W, 4, width of each position counter.
- FILTER_LEN, 4, number of cycles a synchronised clock level must stay stable to be accepted. Used only when the filter feature is compiled in.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flip  in  1  cocktail flip; inverts the counting direction of both axes.
- h_clk  in  1  horizontal step clock; each toggle is one step. Asynchronous to clk.
- h_dir  in  1  horizontal direction; 1 = negative. Asynchronous.
- v_clk  in  1  vertical step clock; each toggle is one step. Asynchronous.
- v_dir  in  1  vertical direction; 1 = negative. Asynchronous.
- rd_h  in  1  CPU horizontal read strobe; freezes the horizontal outputs while high.
- rd_v  in  1  CPU vertical read strobe; freezes the vertical outputs while high.
- h_pos  out  AXIS_W  horizontal count presented to the CPU.
- h_sign  out  1  direction of the last horizontal step presented to the CPU.
- v_pos  out  AXIS_W  vertical count presented to the CPU.
- v_sign  out  1  direction of the last vertical step presented to the CPU.

Behaviour:
- Reset: all outputs, counters, synchroniser flops and sign registers are 0. Assertion is asynchronous and takes effect immediately, including in the middle of counting; release is synchronous to clk.
- Synchronisation: each axis's clk and dir inputs pass through a 2-flop synchroniser. A third flop holds the previous synchronised clk level.
- Step detection:
  - A step is any change (rising or falling) of the synchronised clk.
  - The effective direction is the synchronised dir XOR flip.
- Priming after reset: step detection is suppressed for the first 3 cycles after reset release. An input clk already high at release therefore produces no spurious step.
- Counting, per axis and per step:
  - Effective dir = 0: count <= count + 1.
  - Effective dir = 1: count <= count - 1.
  - Arithmetic is modulo 2^AXIS_W: 15+1 wraps to 0 and 0-1 wraps to 15. There is no saturation.
  - sign <= effective dir on every step.
  - At most one step per axis per cycle. Both axes may step in the same cycle independently.
- Output register, per axis:
  - When rd_x is low, the output {x_pos, x_sign} loads {count, sign} every cycle.
  - When rd_x is high, the output holds its value. Steps that occur during the hold still update the internal count and are visible on the first cycle after rd_x falls.
  - If a step and rd_x rising occur in the same cycle, the output shows the pre-step value.
- Latency: an input toggle first sampled at clock edge k appears on x_pos at edge k+4 (rd low, unfiltered).
- Input rate: toggles spaced at least 3 clk cycles apart are never lost. Faster toggling is out of spec and may drop steps.
- Changing flip mid-motion affects only subsequent steps; the accumulated count is not altered.

Optional Feature:
- Macro: TRACKBALL_FILTER_EN.
- Defined:
  - A new synchronised clk level is accepted as a step only after it has stayed stable for FILTER_LEN consecutive cycles.
  - Pulses shorter than FILTER_LEN cycles are ignored.
  - Latency becomes 4+FILTER_LEN cycles.
  - The minimum spacing between toggles becomes FILTER_LEN+3 cycles.
- Undefined: no filter logic or stability counter is present; behaviour is exactly as described above.

Decomposition:
- Package trackball_pkg:
  - AXIS_W and FILTER_LEN defaults.
  - The priming cycle count constant (3).
  - Position typedef: logic [AXIS_W-1:0].
- Sub-module trackball_axis contains the synchroniser, priming, optional filter, up/down counter and held output register. It is instantiated twice, once for h and once for v. The top level only distributes flip and rd_h/rd_v.

Test Plan:
- Reset with h_clk=1, v_clk=1, then release with no further toggles -> h_pos=v_pos=0 and signs=0 after 10 cycles (priming blocks the spurious step).
- 5 h_clk toggles with h_dir=0, 8 cycles apart -> h_pos=5, h_sign=0, v_pos unchanged at 0. The first change is visible exactly 4 cycles after the first sampled toggle.
- h_pos=1, then 3 toggles with h_dir=1 -> h_pos=14, h_sign=1. Then 18 toggles with h_dir=0 -> h_pos=0 (wraps twice through 15).
- flip=1, 2 v_clk toggles with v_dir=0 -> v_pos=14, v_sign=1. Simultaneous h_clk toggles on the same cycles are all counted on h.
- Hold rd_h high for 20 cycles while 3 up-steps arrive -> h_pos stays frozen at its prior value (e.g. 7). It shows 10 on the cycle after rd_h falls.
- With TRACKBALL_FILTER_EN, FILTER_LEN=4: a 2-cycle h_clk pulse -> h_pos unchanged. A sustained toggle -> count increments after 8 cycles. Assert reset_n low mid-count -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/trackball_pkg.sv
// Shared constants and types for the trackball position counter.
// The optional input glitch filter is enabled by defining TRACKBALL_FILTER_EN.
package trackball_pkg;

  localparam int DEF_AXIS_W     = 4;
  localparam int DEF_FILTER_LEN = 4;
  localparam int PRIME_CYCLES   = 3;

  typedef logic [DEF_AXIS_W-1:0] pos_t;

endpackage

// File: rtl/trackball_axis.sv
// One axis: synchronise the step clock/direction, detect steps, count up/down
// and present a CPU register that freezes while rd is held. Filter: TRACKBALL_FILTER_EN.
module trackball_axis
  import trackball_pkg::*;
#(
  parameter int AXIS_W = DEF_AXIS_W
`ifdef TRACKBALL_FILTER_EN
  ,
  parameter int FILTER_LEN = DEF_FILTER_LEN
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flip,
  input  logic              step_clk,
  input  logic              step_dir,
  input  logic              rd,
  output logic [AXIS_W-1:0] pos,
  output logic              sign
);

  localparam logic [AXIS_W-1:0] ONE = AXIS_W'(1);

  logic [1:0]        clk_sync_r;
  logic [1:0]        dir_sync_r;
  logic              prev_r;
  logic [1:0]        prime_cnt_r;
  logic              prime_done_s;
  logic              lvl_s;
  logic              step_s;
  logic              eff_dir_s;
  logic              step_r;
  logic              dir_r;
  logic [AXIS_W-1:0] count_r;
  logic              sign_r;
  logic [AXIS_W-1:0] pos_r;
  logic              pos_sign_r;

  assign prime_done_s = (prime_cnt_r == 2'(PRIME_CYCLES));

`ifdef TRACKBALL_FILTER_EN
  localparam int STAB_W = $clog2(FILTER_LEN) + 1;

  logic              filt_r;
  logic [STAB_W-1:0] stab_cnt_r;

  // Accept a new synchronised level only after FILTER_LEN stable cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_r     <= 1'b0;
      stab_cnt_r <= '0;
    end else if (!prime_done_s) begin
      filt_r     <= clk_sync_r[1];
      stab_cnt_r <= '0;
    end else if (clk_sync_r[1] == filt_r) begin
      stab_cnt_r <= '0;
    end else if (stab_cnt_r == STAB_W'(FILTER_LEN - 1)) begin
      filt_r     <= clk_sync_r[1];
      stab_cnt_r <= '0;
    end else begin
      stab_cnt_r <= stab_cnt_r + STAB_W'(1);
    end
  end

  assign lvl_s = filt_r;
`else
  assign lvl_s = clk_sync_r[1];
`endif

  // Synchronisers, previous-level flop and post-reset priming counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_r  <= 2'b00;
      dir_sync_r  <= 2'b00;
      prev_r      <= 1'b0;
      prime_cnt_r <= 2'b00;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], step_clk};
      dir_sync_r  <= {dir_sync_r[0], step_dir};
      // While priming, track the raw level so a high input at release is not a step
      prev_r      <= prime_done_s ? lvl_s : clk_sync_r[1];
      prime_cnt_r <= prime_done_s ? prime_cnt_r : prime_cnt_r + 2'd1;
    end
  end

  // Step detection on either edge of the accepted level
  always_comb begin
    step_s    = 1'b0;
    eff_dir_s = dir_sync_r[1] ^ flip;
    if (prime_done_s) begin
      step_s = lvl_s ^ prev_r;
    end else begin
      step_s = 1'b0;
    end
  end

  // Registered step, wrapping up/down counter and CPU-facing hold register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_r     <= 1'b0;
      dir_r      <= 1'b0;
      count_r    <= '0;
      sign_r     <= 1'b0;
      pos_r      <= '0;
      pos_sign_r <= 1'b0;
    end else begin
      step_r <= step_s;
      dir_r  <= eff_dir_s;
      if (step_r) begin
        count_r <= dir_r ? (count_r - ONE) : (count_r + ONE);
        sign_r  <= dir_r;
      end
      if (!rd) begin
        pos_r      <= count_r;
        pos_sign_r <= sign_r;
      end
    end
  end

  assign pos  = pos_r;
  assign sign = pos_sign_r;

endmodule

// File: rtl/trackball_counter.sv
// Two-axis trackball position counter with tear-free CPU read registers.
// Optional input glitch filter enabled by defining TRACKBALL_FILTER_EN.
module trackball_counter
  import trackball_pkg::*;
#(
  parameter int AXIS_W = DEF_AXIS_W
`ifdef TRACKBALL_FILTER_EN
  ,
  parameter int FILTER_LEN = DEF_FILTER_LEN
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flip,
  input  logic              h_clk,
  input  logic              h_dir,
  input  logic              v_clk,
  input  logic              v_dir,
  input  logic              rd_h,
  input  logic              rd_v,
  output logic [AXIS_W-1:0] h_pos,
  output logic              h_sign,
  output logic [AXIS_W-1:0] v_pos,
  output logic              v_sign
);

`ifdef TRACKBALL_FILTER_EN
  trackball_axis #(.AXIS_W(AXIS_W), .FILTER_LEN(FILTER_LEN)) u_h_axis (
`else
  trackball_axis #(.AXIS_W(AXIS_W)) u_h_axis (
`endif
    .clk      (clk),
    .reset_n  (reset_n),
    .flip     (flip),
    .step_clk (h_clk),
    .step_dir (h_dir),
    .rd       (rd_h),
    .pos      (h_pos),
    .sign     (h_sign)
  );

`ifdef TRACKBALL_FILTER_EN
  trackball_axis #(.AXIS_W(AXIS_W), .FILTER_LEN(FILTER_LEN)) u_v_axis (
`else
  trackball_axis #(.AXIS_W(AXIS_W)) u_v_axis (
`endif
    .clk      (clk),
    .reset_n  (reset_n),
    .flip     (flip),
    .step_clk (v_clk),
    .step_dir (v_dir),
    .rd       (rd_v),
    .pos      (v_pos),
    .sign     (v_sign)
  );

endmodule

// File: tb/tb_trackball_counter.sv
// Directed self-checking bench for trackball_counter (default build, or with TRACKBALL_FILTER_EN).
module tb_trackball_counter;
  import trackball_pkg::*;

`ifdef TRACKBALL_FILTER_EN
  localparam int LAT = 4 + DEF_FILTER_LEN;
`else
  localparam int LAT = 4;
`endif
  localparam int SP = 8;

  logic clk = 1'b0;
  logic reset_n, flip, h_clk, h_dir, v_clk, v_dir, rd_h, rd_v;
  pos_t h_pos, v_pos;
  logic h_sign, v_sign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trackball_counter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flip    (flip),
    .h_clk   (h_clk),
    .h_dir   (h_dir),
    .v_clk   (v_clk),
    .v_dir   (v_dir),
    .rd_h    (rd_h),
    .rd_v    (rd_v),
    .h_pos   (h_pos),
    .h_sign  (h_sign),
    .v_pos   (v_pos),
    .v_sign  (v_sign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Toggle h n times in direction d, SP cycles apart
  task automatic toggle_h(input int n, input logic d);
    for (int i = 0; i < n; i++) begin
      h_dir = d;
      h_clk = ~h_clk;
      wait_neg(SP);
    end
  endtask

  initial begin
    reset_n = 1'b0; flip = 1'b0;
    h_clk = 1'b1; h_dir = 1'b0; v_clk = 1'b1; v_dir = 1'b0;
    rd_h = 1'b0; rd_v = 1'b0;
    wait_neg(3);
    chk("rst_h_pos", h_pos, 0);
    chk("rst_v_pos", v_pos, 0);
    chk("rst_h_sign", h_sign, 0);
    chk("rst_v_sign", v_sign, 0);

    reset_n = 1'b1;
    wait_neg(10);
    chk("prime_h_pos", h_pos, 0);
    chk("prime_v_pos", v_pos, 0);
    chk("prime_h_sign", h_sign, 0);
    chk("prime_v_sign", v_sign, 0);

    // First toggle: latency check
    h_dir = 1'b0;
    h_clk = ~h_clk;
    wait_neg(LAT);
    chk("lat_before", h_pos, 0);
    wait_neg(1);
    chk("lat_at", h_pos, 1);
    wait_neg(SP - LAT - 1);
    toggle_h(4, 1'b0);
    chk("up5_h_pos", h_pos, 5);
    chk("up5_h_sign", h_sign, 0);
    chk("up5_v_pos", v_pos, 0);

    toggle_h(12, 1'b0);
    chk("wrap_up_h_pos", h_pos, 1);
    toggle_h(3, 1'b1);
    chk("down_h_pos", h_pos, 14);
    chk("down_h_sign", h_sign, 1);
    toggle_h(18, 1'b0);
    chk("wrap2_h_pos", h_pos, 0);
    chk("wrap2_h_sign", h_sign, 0);

    // Flip with simultaneous steps on both axes
    flip = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v_dir = 1'b0;
      v_clk = ~v_clk;
      h_dir = 1'b0;
      h_clk = ~h_clk;
      wait_neg(SP);
    end
    chk("flip_v_pos", v_pos, 14);
    chk("flip_v_sign", v_sign, 1);
    chk("flip_h_pos", h_pos, 14);
    chk("flip_h_sign", h_sign, 1);
    flip = 1'b0;

    toggle_h(9, 1'b0);
    chk("pre_hold_h_pos", h_pos, 7);

    // Freeze h while three up-steps arrive
    rd_h = 1'b1;
    toggle_h(3, 1'b0);
    chk("hold_mid_h_pos", h_pos, 7);
    chk("hold_h_sign", h_sign, 0);
    wait_neg(2);
    chk("hold_end_h_pos", h_pos, 7);
    chk("hold_v_pos", v_pos, 14);
    rd_h = 1'b0;
    wait_neg(1);
    chk("release_h_pos", h_pos, 10);

`ifdef TRACKBALL_FILTER_EN
    h_clk = ~h_clk;
    wait_neg(2);
    h_clk = ~h_clk;
    wait_neg(2 * SP);
    chk("glitch_h_pos", h_pos, 10);
`endif

    // Asynchronous reset mid-count
    toggle_h(1, 1'b0);
    chk("pre_rst_h_pos", h_pos, 11);
    h_clk = ~h_clk;
    wait_neg(2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_h_pos", h_pos, 0);
    chk("async_h_sign", h_sign, 0);
    chk("async_v_pos", v_pos, 0);
    chk("async_v_sign", v_sign, 0);
    wait_neg(2);
    reset_n = 1'b1;
    wait_neg(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
